// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB to produce forwarding selects, load-use
// and multiply stalls, branch flushes, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_ra_idx,
  input  logic [4:0]  id_rb_idx,
  input  logic        id_uses_ra,
  input  logic        id_uses_rb,
  input  logic        id_reg_wr,
  input  logic [4:0]  id_dest_idx,
  input  logic        id_rd_mem,
  input  logic        id_is_mul,
  input  logic        ex_take_branch,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        hold_ex,
  output logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] dest;
    logic       ld;
    logic       mul;
  } entry_t;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  entry_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_rec;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        busy, flush_c, load_use;

  function automatic logic producing(entry_t e);
    return e.v & e.wr & (e.dest != 5'd0);
  endfunction

  // Youngest producer wins; a load in EX never forwards (load-use stall covers it).
  function automatic logic [1:0] fwd_sel(logic used, logic [4:0] idx, entry_t ex, entry_t mem,
                                         entry_t wb, logic is_busy);
    logic [1:0] sel;
    sel = 2'd0;
    if (!used || idx == 5'd0) begin
      sel = 2'd0;
    end else if (producing(ex) && ex.dest == idx && ex.ld) begin
      sel = 2'd0;
    end else if (producing(ex) && ex.dest == idx && !is_busy) begin
      sel = 2'd1;
    end else if (producing(mem) && mem.dest == idx) begin
      sel = 2'd2;
    end else if (producing(wb) && wb.dest == idx) begin
      sel = 2'd3;
    end
    return sel;
  endfunction

  assign id_rec = '{v: 1'b1, wr: id_reg_wr, dest: id_dest_idx, ld: id_rd_mem, mul: id_is_mul};

  assign busy     = (state_q == StBusy);
  assign flush_c  = ~busy & ex_q.v & ex_take_branch;
  assign load_use = ~busy & ~flush_c & producing(ex_q) & ex_q.ld &
                    ((id_uses_ra && id_ra_idx == ex_q.dest) ||
                     (id_uses_rb && id_rb_idx == ex_q.dest));

  assign stall_if  = busy | load_use;
  assign stall_id  = busy | load_use;
  assign bubble_ex = load_use;
  assign hold_ex   = busy;
  assign flush     = flush_c;
  assign fwd_a_sel = fwd_sel(id_uses_ra, id_ra_idx, ex_q, mem_q, wb_q, busy);
  assign fwd_b_sel = fwd_sel(id_uses_rb, id_rb_idx, ex_q, mem_q, wb_q, busy);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = '0;
    mem_d   = ex_q;
    wb_d    = mem_q;
    if (busy) begin
      ex_d  = ex_q;
      mem_d = '0;
      cnt_d = cnt_q - 4'd1;
      if (cnt_d == 4'd0) state_d = StIdle;
    end else begin
      if (id_valid && !load_use && !flush_c) ex_d = id_rec;
      // The MUL spends MUL_LAT-1 cycles in BUSY plus one final IDLE cycle in EX.
      if (MUL_LAT > 1 && ex_d.v && ex_d.mul) begin
        state_d = StBusy;
        cnt_d   = 4'(MUL_LAT - 1);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_c && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Load/mul flags are only meaningful while an entry sits in EX.
  logic unused_bits;
  assign unused_bits = ^{mem_q.ld, mem_q.mul, wb_q.ld, wb_q.mul};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl: a cycle-by-cycle instruction stream with
// hand-computed control outputs, plus a hand-written reset-during-multiply sequence.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_ra, id_uses_rb, id_reg_wr, id_rd_mem, id_is_mul;
  logic [4:0]  id_ra_idx, id_rb_idx, id_dest_idx;
  logic        ex_take_branch;
  logic        stall_if, stall_id, bubble_ex, hold_ex, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_ra_idx      (id_ra_idx),
    .id_rb_idx      (id_rb_idx),
    .id_uses_ra     (id_uses_ra),
    .id_uses_rb     (id_uses_rb),
    .id_reg_wr      (id_reg_wr),
    .id_dest_idx    (id_dest_idx),
    .id_rd_mem      (id_rd_mem),
    .id_is_mul      (id_is_mul),
    .ex_take_branch (ex_take_branch),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .hold_ex        (hold_ex),
    .flush          (flush),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  // {stall_if, stall_id, bubble_ex, hold_ex, flush, fwd_a, fwd_b, stall_cnt, flush_cnt}
  logic [72:0] obs;
  assign obs = {stall_if, stall_id, bubble_ex, hold_ex, flush, fwd_a_sel, fwd_b_sel,
                stall_cnt, flush_cnt};

  typedef struct {
    logic        v;
    logic [4:0]  ra, rb;
    logic        ua, ub, wr;
    logic [4:0]  rd;
    logic        ld, mul, br;
    logic [72:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[21];

  function automatic vec_t mk(logic v, int ra, int rb, logic ua, logic ub, logic wr, int rd,
                              logic ld, logic mul, logic br, logic sif, logic bub, logic hold,
                              logic fl, int fa, int fb, int sc, int fc);
    vec_t t;
    t.v = v; t.ra = 5'(ra); t.rb = 5'(rb); t.ua = ua; t.ub = ub; t.wr = wr; t.rd = 5'(rd);
    t.ld = ld; t.mul = mul; t.br = br;
    t.exp = {sif, sif, bub, hold, fl, 2'(fa), 2'(fb), 32'(sc), 32'(fc)};
    return t;
  endfunction

  task automatic drive(vec_t t);
    id_valid = t.v; id_ra_idx = t.ra; id_rb_idx = t.rb; id_uses_ra = t.ua;
    id_uses_rb = t.ub; id_reg_wr = t.wr; id_dest_idx = t.rd; id_rd_mem = t.ld;
    id_is_mul = t.mul; ex_take_branch = t.br;
  endtask

  task automatic check(string name, logic [72:0] got, logic [72:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got sif=%b sid=%b bub=%b hold=%b fl=%b fa=%0d fb=%0d sc=%0d fc=%0d ; want sif=%b sid=%b bub=%b hold=%b fl=%b fa=%0d fb=%0d sc=%0d fc=%0d",
               name, got[72], got[71], got[70], got[69], got[68], got[67:66], got[65:64],
               got[63:32], got[31:0], exp[72], exp[71], exp[70], exp[69], exp[68],
               exp[67:66], exp[65:64], exp[63:32], exp[31:0]);
    end
  endtask

  initial begin
    vec_t idle;
    //            v  ra rb ua ub wr rd ld mul br sif bub hold fl fa fb sc fc
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 2, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // add x5
    vecs[2]  = mk(1, 5, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);  // sub x6,x5,x5
    vecs[3]  = mk(1, 5, 6, 1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    vecs[4]  = mk(1, 5, 6, 1, 1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0);
    vecs[5]  = mk(1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // lw x7
    vecs[6]  = mk(1, 7, 1, 1, 1, 1, 8, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // add x8,x7,x1
    vecs[7]  = mk(1, 7, 1, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    vecs[8]  = mk(1, 1, 2, 1, 1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // mul x9
    vecs[9]  = mk(1, 9, 3, 1, 1, 1, 12, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    vecs[10] = mk(1, 9, 3, 1, 1, 1, 12, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 0);
    vecs[11] = mk(1, 9, 3, 1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
    vecs[12] = mk(1, 1, 0, 1, 0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0); // lw x13
    vecs[13] = mk(1, 13, 13, 1, 1, 1, 14, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0); // branch taken
    vecs[14] = mk(1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3, 1);
    vecs[15] = mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);  // addi x0
    vecs[16] = mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);  // addi x0
    vecs[17] = mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);  // lw x0
    vecs[18] = mk(1, 0, 0, 1, 1, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1); // reads x0
    vecs[19] = mk(1, 1, 2, 1, 1, 1, 16, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1); // mul x16
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3, 1);  // busy cycle 1

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    rst = 1'b0;
    #1 check("reset", obs, idle.exp);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Second BUSY cycle, then asynchronous reset in the middle of it.
    @(negedge clk);
    drive(idle);
    #1 check("busy2", obs, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4, 1).exp);
    #1 rst = 1'b0;
    #1 check("async_rst", obs, idle.exp);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(1, 1, 0, 1, 0, 1, 17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check("post_rst_add17", obs, idle.exp);
    @(negedge clk);
    drive(mk(1, 17, 16, 1, 1, 1, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check("post_rst_fwd", obs, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0).exp);
    @(negedge clk);
    drive(idle);
    #1 check("post_rst_idle", obs, idle.exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
